// File: rtl/temp_uart_framer.sv
// Packs 16-bit DS18B20 samples into 5-byte frames (header, seq, hi, lo, checksum)
// and paces them into a UART transmitter at one byte every BYTE_GAP clocks.
module temp_uart_framer #(
  parameter int unsigned BYTE_GAP = 30000,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [7:0]  seq,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned    GW       = $clog2(BYTE_GAP);
  localparam logic [GW-1:0]  GAP_LAST = GW'(BYTE_GAP - 2);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t          state;
  logic [2:0]      byte_idx;
  logic [2:0]      next_idx;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      frame_seq;
  logic [7:0]      data_hi;
  logic [7:0]      data_lo;
  logic [7:0]      checksum;
  logic [7:0]      next_byte;

  assign next_idx = byte_idx + 3'd1;

  always_comb begin
    next_byte = checksum;
    case (next_idx)
      3'd1:    next_byte = frame_seq;
      3'd2:    next_byte = data_hi;
      3'd3:    next_byte = data_lo;
      default: next_byte = checksum;
    endcase
  end

  // SEND is the single cycle tx_wr is high; GAP burns the remaining BYTE_GAP-1 cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      byte_idx  <= '0;
      gap_cnt   <= '0;
      frame_seq <= '0;
      data_hi   <= '0;
      data_lo   <= '0;
      checksum  <= '0;
      tx_wr     <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
      seq       <= '0;
      drop_cnt  <= '0;
    end else begin
      if (sample_valid && busy && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (sample_valid) begin
            frame_seq <= seq;
            data_hi   <= sample_data[15:8];
            data_lo   <= sample_data[7:0];
            checksum  <= HEADER + seq + sample_data[15:8] + sample_data[7:0];
            seq       <= seq + 8'd1;
            byte_idx  <= '0;
            tx_wr     <= 1'b1;
            tx_data   <= HEADER;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end

        SEND: begin
          tx_wr   <= 1'b0;
          gap_cnt <= '0;
          state   <= GAP;
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            if (byte_idx == 3'd4) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              byte_idx <= next_idx;
              tx_wr    <= 1'b1;
              tx_data  <= next_byte;
              state    <= SEND;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
